// File: rtl/gnrc_therm_decoder.sv
// Two-stage thermometer-to-onehot/binary decoder with optional 3-tap majority
// bubble correction, valid/ready flow control and a saturating illegal-word counter.
module gnrc_therm_decoder #(
    parameter int N          = 7,
    parameter int M          = N + 1,
    parameter int W          = $clog2(N + 1),
    parameter bit BUBBLE_FIX = 1'b1,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [N-1:0]         therm_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [M-1:0]         onehot_o,
    output logic [W-1:0]         bin_o,
    output logic                 bubble_o,
    output logic                 illegal_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    function automatic logic non_mono(input logic [N-1:0] x);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < N - 1; k++)
            bad = bad | (~x[k] & x[k+1]);
        return bad;
    endfunction

    function automatic logic [W-1:0] popcnt(input logic [N-1:0] x);
        logic [W-1:0] cnt;
        cnt = '0;
        for (int k = 0; k < N; k++)
            cnt = cnt + W'(x[k]);
        return cnt;
    endfunction

    logic [N+1:0]         w_ext;
    logic [N-1:0]         w_maj;
    logic [N-1:0]         w_corr;
    logic                 w_raw_bad;
    logic                 w_ill;
    logic                 w_bub;
    logic                 w_ld1;
    logic                 w_ld2;
    logic [W-1:0]         w_bin;
    logic [M-1:0]         w_oh;

    logic                 r_v1;
    logic [N-1:0]         r_c1;
    logic                 r_bub1;
    logic                 r_ill1;
    logic                 r_v2;
    logic [W-1:0]         r_bin2;
    logic [M-1:0]         r_oh2;
    logic                 r_bub2;
    logic                 r_ill2;
    logic [ERR_CNT_W-1:0] r_err;

    // Virtual taps: below tap 0 reads as 1, above tap N-1 reads as 0.
    assign w_ext = {1'b0, therm_i, 1'b1};

    always_comb begin
        w_maj = '0;
        for (int k = 0; k < N; k++)
            w_maj[k] = (w_ext[k] & w_ext[k+1]) | (w_ext[k] & w_ext[k+2]) |
                       (w_ext[k+1] & w_ext[k+2]);
    end

    assign w_corr    = BUBBLE_FIX ? w_maj : therm_i;
    assign w_raw_bad = non_mono(therm_i);
    assign w_ill     = non_mono(w_corr);
    assign w_bub     = w_raw_bad & ~w_ill;

    assign w_bin = popcnt(r_c1);
    assign w_oh  = M'(1) << w_bin;

    assign w_ld2   = ~r_v2 | ready_i;
    assign w_ld1   = ~r_v1 | w_ld2;
    assign ready_o = w_ld1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_v1   <= 1'b0;
            r_c1   <= '0;
            r_bub1 <= 1'b0;
            r_ill1 <= 1'b0;
        end else if (w_ld1) begin
            r_v1 <= valid_i;
            if (valid_i) begin
                r_c1   <= w_corr;
                r_bub1 <= w_bub;
                r_ill1 <= w_ill;
            end
        end
    end

    // Output data only changes when a new word moves in, so it holds under backpressure.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_v2   <= 1'b0;
            r_bin2 <= '0;
            r_oh2  <= '0;
            r_bub2 <= 1'b0;
            r_ill2 <= 1'b0;
        end else if (w_ld2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_bin2 <= w_bin;
                r_oh2  <= w_oh;
                r_bub2 <= r_bub1;
                r_ill2 <= r_ill1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_err <= '0;
        else if (clr_i)
            r_err <= '0;
        else if (r_v2 && ready_i && r_ill2 && !(&r_err))
            r_err <= r_err + 1'b1;
    end

    assign valid_o   = r_v2;
    assign onehot_o  = r_oh2;
    assign bin_o     = r_bin2;
    assign bubble_o  = r_bub2;
    assign illegal_o = r_ill2;
    assign err_cnt_o = r_err;

endmodule

// File: tb/tb_gnrc_therm_decoder.sv
// Random and directed stimulus for two decoder instances (correction on / off,
// 8-bit / 2-bit error counter) sharing one input stream, checked against a word-level model.
module tb_gnrc_therm_decoder;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       clr_i;
    logic       valid_i;
    logic [6:0] therm_i;
    logic       ready_i;

    logic       a_ready, a_valid, a_bub, a_ill;
    logic [7:0] a_oh;
    logic [2:0] a_bin;
    logic [7:0] a_err;
    logic       b_ready, b_valid, b_bub, b_ill;
    logic [7:0] b_oh;
    logic [2:0] b_bin;
    logic [1:0] b_err;

    int n_tests = 0;
    int n_fail  = 0;
    int ncyc    = 0;

    typedef struct {
        int         acc;
        logic [6:0] t;
    } word_t;
    word_t q[$];
    int    ea = 0;
    int    eb = 0;

    gnrc_therm_decoder #(.N(7), .BUBBLE_FIX(1'b1), .ERR_CNT_W(8)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_ni), .clr_i(clr_i), .valid_i(valid_i), .ready_o(a_ready),
        .therm_i(therm_i), .valid_o(a_valid), .ready_i(ready_i), .onehot_o(a_oh),
        .bin_o(a_bin), .bubble_o(a_bub), .illegal_o(a_ill), .err_cnt_o(a_err));

    gnrc_therm_decoder #(.N(7), .BUBBLE_FIX(1'b0), .ERR_CNT_W(2)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_ni), .clr_i(clr_i), .valid_i(valid_i), .ready_o(b_ready),
        .therm_i(therm_i), .valid_o(b_valid), .ready_i(ready_i), .onehot_o(b_oh),
        .bin_o(b_bin), .bubble_o(b_bub), .illegal_o(b_ill), .err_cnt_o(b_err));

    always #5 clk = ~clk;
    always @(posedge clk) ncyc++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, ncyc);
        end
    endtask

    // A word is a legal thermometer code exactly when it equals 2^popcount - 1.
    function automatic bit is_legal(input logic [6:0] x);
        return int'(x) == ((1 << $countones(x)) - 1);
    endfunction

    function automatic logic [6:0] fix(input logic [6:0] t);
        int         b[0:8];
        logic [6:0] c;
        b[0] = 1;
        b[8] = 0;
        for (int k = 0; k < 7; k++) b[k+1] = int'(t[k]);
        for (int k = 0; k < 7; k++) c[k] = (b[k] + b[k+1] + b[k+2]) >= 2;
        return c;
    endfunction

    task automatic step(input logic v, input logic [6:0] t, input logic r, input logic c);
        bit         exp_valid, exp_ready, ill_a, ill_b;
        logic [6:0] ca, cb;
        @(negedge clk);
        valid_i = v; therm_i = t; ready_i = r; clr_i = c;
        #1;
        exp_ready = (q.size() < 2) || r;
        exp_valid = (q.size() > 0) && (q[0].acc + 2 <= ncyc);
        check_eq("a_ready", a_ready, exp_ready);
        check_eq("b_ready", b_ready, exp_ready);
        check_eq("a_valid", a_valid, exp_valid);
        check_eq("b_valid", b_valid, exp_valid);
        ill_a = 1'b0; ill_b = 1'b0;
        if (exp_valid) begin
            ca = fix(q[0].t);
            cb = q[0].t;
            ill_a = !is_legal(ca);
            ill_b = !is_legal(cb);
            check_eq("a_bin", a_bin, $countones(ca));
            check_eq("a_onehot", a_oh, 1 << $countones(ca));
            check_eq("a_illegal", a_ill, ill_a);
            check_eq("a_bubble", a_bub, !is_legal(q[0].t) && !ill_a);
            check_eq("b_bin", b_bin, $countones(cb));
            check_eq("b_onehot", b_oh, 1 << $countones(cb));
            check_eq("b_illegal", b_ill, ill_b);
            check_eq("b_bubble", b_bub, 0);
        end
        check_eq("a_err", a_err, ea);
        check_eq("b_err", b_err, eb);
        if (c) begin
            ea = 0; eb = 0;
        end else if (exp_valid && r) begin
            if (ill_a) ea = (ea == 255) ? 255 : ea + 1;
            if (ill_b) eb = (eb == 3) ? 3 : eb + 1;
        end
        if (exp_valid && r) void'(q.pop_front());
        if (v && exp_ready) q.push_back('{acc: ncyc, t: t});
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_a_valid"}, a_valid, 0);
        check_eq({tag, "_b_valid"}, b_valid, 0);
        check_eq({tag, "_a_onehot"}, a_oh, 0);
        check_eq({tag, "_a_bin"}, a_bin, 0);
        check_eq({tag, "_a_flags"}, {a_bub, a_ill}, 0);
        check_eq({tag, "_a_err"}, a_err, 0);
        check_eq({tag, "_b_err"}, b_err, 0);
        check_eq({tag, "_a_ready"}, a_ready, 1);
    endtask

    initial begin
        logic [6:0] t;
        int         sel;
        rst_ni = 1'b0; clr_i = 1'b0; valid_i = 1'b0; therm_i = '0; ready_i = 1'b0;
        #3;
        check_reset_state("reset");
        @(negedge clk); @(negedge clk);
        rst_ni = 1'b1;

        // Legal words, bubble-correctable word, uncorrectable word.
        step(1, 7'b000_0111, 1, 0);
        step(1, 7'b000_0000, 1, 0);
        step(1, 7'b111_1111, 1, 0);
        step(1, 7'b000_1011, 1, 0);
        step(1, 7'b110_0001, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 7'b0, 1, 0);

        // Backpressure: A, B buffered, C held until ready_i rises.
        step(1, 7'b000_0001, 0, 0);
        step(1, 7'b000_0011, 0, 0);
        step(1, 7'b001_1111, 0, 0);
        step(1, 7'b001_1111, 0, 0);
        step(1, 7'b001_1111, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 7'b0, 1, 0);

        // Saturation of the 2-bit counter, then clear against an illegal handshake.
        for (int i = 0; i < 5; i++) step(1, 7'b110_0001, 1, 0);
        for (int i = 0; i < 2; i++) step(0, 7'b0, 1, 0);
        step(1, 7'b110_0001, 1, 0);
        step(0, 7'b0, 1, 0);
        step(0, 7'b0, 1, 1);
        step(0, 7'b0, 1, 0);

        for (int i = 0; i < 500; i++) begin
            sel = $urandom_range(0, 2);
            t   = 7'((1 << $urandom_range(0, 7)) - 1);
            if (sel == 1) t = t ^ 7'(1 << $urandom_range(0, 6));
            if (sel == 2) t = 7'($urandom);
            step($urandom_range(0, 3) != 0, t, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 40) == 0);
        end

        // Reset with two words in flight and non-zero error counts.
        for (int i = 0; i < 2; i++) step(1, 7'b110_0001, 1, 0);
        step(0, 7'b0, 1, 0);
        step(1, 7'b000_0111, 0, 0);
        step(1, 7'b110_0001, 0, 0);
        @(negedge clk);
        valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        check_reset_state("midrst");
        q.delete(); ea = 0; eb = 0;
        @(negedge clk);
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) step(0, 7'b0, 1, 0);
        step(1, 7'b011_1111, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 7'b0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
